// File: rtl/cam_assoc_if.sv
// Lookup/write/flush signal bundle between a cache controller (master) and cam_assoc (slave).
interface cam_assoc_if #(
  parameter int WAYS   = 4,
  parameter int TAG_W  = 17,
  parameter int FLAG_W = 2,
  parameter int IDX_W  = 10
);
  logic              read_req;
  logic [IDX_W-1:0]  read_index;
  logic [TAG_W-1:0]  read_tag_in;
  logic              read_hit;
  logic [WAYS-1:0]   read_way;
  logic [TAG_W-1:0]  read_tag_out;
  logic [31:0]       read_data;
  logic [FLAG_W-1:0] read_flags;
  logic [IDX_W-1:0]  write_index;
  logic              write_req_data;
  logic [31:0]       write_data;
  logic [3:0]        write_mask;
  logic              write_req_tag_flags;
  logic [TAG_W-1:0]  write_tag;
  logic [FLAG_W-1:0] write_flags;
  logic              flush_req;
  logic              flush_busy;

  modport slave (
    input  read_req, read_index, read_tag_in,
    output read_hit, read_way, read_tag_out, read_data, read_flags,
    input  write_index, write_req_data, write_data, write_mask,
    input  write_req_tag_flags, write_tag, write_flags,
    input  flush_req,
    output flush_busy
  );

  modport master (
    output read_req, read_index, read_tag_in,
    input  read_hit, read_way, read_tag_out, read_data, read_flags,
    output write_index, write_req_data, write_data, write_mask,
    output write_req_tag_flags, write_tag, write_flags,
    output flush_req,
    input  flush_busy
  );
endinterface

// File: rtl/cam_assoc.sv
// N-way set-associative tag/flag/data store: registered RAM read, combinational compare in the
// following cycle, tree-PLRU with invalid-first victims, and a one-set-per-cycle invalidate sweep.
module cam_assoc #(
  parameter int WAYS       = 4,
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 17,
  parameter int FLAG_W     = 2
) (
  input logic       clk,
  input logic       reset,
  cam_assoc_if.slave bus
);
  localparam int SET_W  = $clog2(SETS);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = SET_W + OFF_W;
  localparam int LVL    = $clog2(WAYS);
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic {IDLE, SWEEP} state_e;

  logic [WAYS*32-1:0]     data_mem [SETS*LINE_WORDS];
  logic [WAYS*TAG_W-1:0]  tag_mem  [SETS];
  logic [WAYS*FLAG_W-1:0] flag_mem [SETS];
  logic [PLRU_W-1:0]      plru_mem [SETS];

  state_e             state_q, state_d;
  logic [SET_W-1:0]   cnt_q, cnt_d;
  logic               busy, sweep_en;

  logic               lkp_vld_q, lkp_new_q;
  logic [SET_W-1:0]   set_q;
  logic [WAYS*32-1:0] data_q;
  logic [WAYS*TAG_W-1:0]  tags_q;
  logic [WAYS*FLAG_W-1:0] flags_q;
  logic [PLRU_W-1:0]  plru_q;

  logic [WAYS-1:0]    hits, hit_oh, inv_oh, way_sel;
  logic               hit_found, inv_found;
  logic [SET_W-1:0]   wset;
  logic               rd_acc, flush_go;

  // Node n at level k decides way bit k; level 0 (root) picks the LSB of the way index.
  function automatic logic [WAYS-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    int   wi;
    logic take;
    wi = 0;
    for (int k = 0; k < LVL; k++) begin
      take = 1'b0;
      for (int n = 0; n < PLRU_W; n++)
        if (n == (1 << k) - 1 + wi) take = bits[n];
      if (take) wi = wi + (1 << k);
    end
    plru_victim = '0;
    for (int i = 0; i < WAYS; i++)
      if (i == wi) plru_victim[i] = 1'b1;
  endfunction

  function automatic logic [PLRU_W-1:0] plru_away(input logic [PLRU_W-1:0] bits,
                                                  input logic [WAYS-1:0]   way_oh);
    int wi;
    plru_away = bits;
    wi = 0;
    for (int i = 0; i < WAYS; i++)
      if (way_oh[i]) wi = i;
    for (int k = 0; k < LVL; k++)
      for (int n = 0; n < PLRU_W; n++)
        if (n == (1 << k) - 1 + (wi & ((1 << k) - 1))) plru_away[n] = (((wi >> k) & 1) == 0);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (bus.flush_req) begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
      SWEEP: begin
        cnt_d = cnt_q + SET_W'(1);
        if (cnt_q == SET_W'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == SWEEP);
    sweep_en = busy;
  end

  assign bus.flush_busy = busy;
  assign rd_acc   = bus.read_req & ~busy;
  assign flush_go = bus.flush_req & ~busy;
  assign wset     = bus.write_index[IDX_W-1:OFF_W];

  // A flush drops the latched lookup so outputs read as zero until the next lookup.
  always_ff @(posedge clk) begin
    if (reset) begin
      lkp_vld_q <= 1'b0;
      lkp_new_q <= 1'b0;
      set_q     <= '0;
      data_q    <= '0;
      tags_q    <= '0;
      flags_q   <= '0;
      plru_q    <= '0;
    end else begin
      lkp_new_q <= rd_acc & ~flush_go;
      if (flush_go) begin
        lkp_vld_q <= 1'b0;
      end else if (rd_acc) begin
        lkp_vld_q <= 1'b1;
        set_q     <= bus.read_index[IDX_W-1:OFF_W];
        data_q    <= data_mem[bus.read_index];
        tags_q    <= tag_mem[bus.read_index[IDX_W-1:OFF_W]];
        flags_q   <= flag_mem[bus.read_index[IDX_W-1:OFF_W]];
        plru_q    <= plru_mem[bus.read_index[IDX_W-1:OFF_W]];
      end
    end
  end

  always_comb begin
    hits      = '0;
    hit_oh    = '0;
    inv_oh    = '0;
    hit_found = 1'b0;
    inv_found = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      hits[i] = flags_q[i*FLAG_W] & (tags_q[i*TAG_W +: TAG_W] == bus.read_tag_in);
      if (hits[i] && !hit_found) begin
        hit_oh[i] = 1'b1;
        hit_found = 1'b1;
      end
      if (!flags_q[i*FLAG_W] && !inv_found) begin
        inv_oh[i] = 1'b1;
        inv_found = 1'b1;
      end
    end
    if (busy || !lkp_vld_q) way_sel = '0;
    else if (hit_found)     way_sel = hit_oh;
    else if (inv_found)     way_sel = inv_oh;
    else                    way_sel = plru_victim(plru_q);
  end

  always_comb begin
    bus.read_hit     = |(way_sel & hits);
    bus.read_way     = way_sel;
    bus.read_tag_out = '0;
    bus.read_data    = '0;
    bus.read_flags   = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (way_sel[i]) begin
        bus.read_tag_out = bus.read_tag_out | tags_q[i*TAG_W +: TAG_W];
        bus.read_data    = bus.read_data    | data_q[i*32 +: 32];
        bus.read_flags   = bus.read_flags   | flags_q[i*FLAG_W +: FLAG_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sweep_en) begin
      flag_mem[cnt_q] <= '0;
      plru_mem[cnt_q] <= '0;
    end else begin
      if (lkp_new_q && bus.read_hit)
        plru_mem[set_q] <= plru_away(plru_mem[set_q], way_sel);
      if (bus.write_req_tag_flags) begin
        for (int w = 0; w < WAYS; w++) begin
          if (way_sel[w]) begin
            tag_mem[wset][w*TAG_W +: TAG_W]    <= bus.write_tag;
            flag_mem[wset][w*FLAG_W +: FLAG_W] <= bus.write_flags;
          end
        end
        if (bus.write_flags[0] && (way_sel != '0))
          plru_mem[wset] <= plru_away(plru_mem[wset], way_sel);
      end
      if (bus.write_req_data) begin
        for (int w = 0; w < WAYS; w++)
          for (int b = 0; b < 4; b++)
            if (way_sel[w] && bus.write_mask[b])
              data_mem[bus.write_index][w*32 + b*8 +: 8] <= bus.write_data[b*8 +: 8];
      end
    end
  end
endmodule

// File: doc/cam_assoc.md
Name: cam_assoc

Overview:
- Parametrised N-way set-associative tag/flag/data store. It is the successor to the 2-way cache CAM and is instantiated by the I-cache and D-cache.
- Provides one-cycle lookup with a delayed tag compare, a masked data write and a tag/flag write. Both writes target the way selected by the most recent lookup.
- Adds tree-PLRU replacement, invalid-way-first victim selection and a hardware invalidate sweep (on reset or on request).

Parameters:
- WAYS, 4: associativity; power of two, 1..8.
- SETS, 256: number of sets; power of two, at least 2.
- LINE_WORDS, 4: 32-bit words per line; power of two.
- TAG_W, 17: tag width.
- FLAG_W, 2: flag width; flag bit 0 is the valid bit.
- Derived, not overridable: SET_W = log2(SETS); OFF_W = log2(LINE_WORDS); IDX_W = SET_W + OFF_W.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- read_req  in  1  start a lookup at read_index.
- read_index  in  IDX_W  word index {set, word offset}.
- read_tag_in  in  TAG_W  compare tag; sampled one cycle after read_req.
- read_hit  out  1  a valid way matched.
- read_way  out  WAYS  one-hot selected way (the hit way, or the victim on a miss).
- read_tag_out  out  TAG_W  tag of read_way.
- read_data  out  32  data word of read_way.
- read_flags  out  FLAG_W  flags of read_way.
- write_index  in  IDX_W  write word index.
- write_req_data  in  1  write write_data into way read_way.
- write_data  in  32  write data.
- write_mask  in  4  byte enables.
- write_req_tag_flags  in  1  write {write_tag, write_flags} into way read_way.
- write_tag  in  TAG_W  new tag.
- write_flags  in  FLAG_W  new flags.
- flush_req  in  1  pulse; invalidate all lines.
- flush_busy  out  1  invalidate sweep in progress.

Behaviour:
- Storage: data RAM of SETS*LINE_WORDS entries x WAYS*32 bits; tag/flag RAM of SETS entries x WAYS*(TAG_W+FLAG_W); PLRU RAM of SETS x (WAYS-1) bits. For WAYS=1 the PLRU RAM is omitted and the victim is always way 0.
- Lookup timing: read_req in cycle N reads all three RAMs. In cycle N+1 the compare with read_tag_in is combinational and drives read_hit/read_way/read_tag_out/read_data/read_flags.
- RAM output registers update only on read_req, so outputs hold until the next read_req. read_tag_in may change freely and the outputs follow it.
- Hit: hits[i] = flags[i][0] & (tag[i] == read_tag_in). read_hit = |hits. If several ways hit, the lowest-index hit way is selected.
- Victim on miss: the lowest-index invalid way; if every way is valid, the way pointed to by the tree-PLRU bits.
- Data/tag/flag outputs are those of read_way. If read_way is all zero, they are all zero.
- PLRU update: in cycle N+1, if read_hit, the PLRU bits of the latched set are written to point away from read_way. There is no PLRU update on a miss. A later tag/flag write that sets valid=1 also updates PLRU to point away from the written way.
- Writes:
  - Writes are single-cycle.
  - The target way is the current read_way, evaluated in the same cycle.
  - Data writes are per byte, using write_mask.
  - Tag/flag writes use set = write_index[IDX_W-1:OFF_W].
  - Data and tag/flag writes may occur in the same cycle.
- Same-address read and write in one cycle: the read returns the old contents (read-first).
- Flush FSM, states IDLE and SWEEP:
  - reset or flush_req: enter SWEEP with set counter = 0.
  - SWEEP, each cycle: clear every way's flags to 0 and the PLRU bits to 0 for the counter's set, then increment the counter.
  - On the counter wrap from SETS-1 to 0: go to IDLE.
  - The sweep takes exactly SETS cycles. Tags and data are not cleared.
- flush_busy = 1 exactly while in SWEEP.
- While busy: read_req, write_req_data, write_req_tag_flags and further flush_req are ignored. Outputs are forced to read_hit=0, read_way=0, and 0 for data/tag/flags.
- Reset asserted mid-sweep restarts the sweep at set 0.
- Reset values: flush_busy=1 and all read outputs 0 in the first cycle after reset is sampled. Outputs stay 0 until the first read_req after the sweep completes.
- A lookup whose cycle N+1 coincides with a flush_req completes normally. The sweep starts in the cycle after flush_req.

Test Plan:
- Reset held 1 cycle with SETS=256 -> flush_busy=1 for exactly 256 cycles. Any lookup afterwards misses with read_way=0001 (WAYS=4).
- Miss on set 5, then tag write 0x1ABCD with flags 01, repeated four times with distinct tags -> the writes fill ways 0,1,2,3 in order (invalid-first). Each tag then hits with its own way and returns the written tag/flags.
- All 4 ways valid in set 7; hit ways 0,1,2 in sequence, then miss -> read_way=1000. Then hit way 3, then miss -> victim is way 0 (PLRU).
- Data write 0xDEADBEEF mask 0101 over 0x11223344 at a hit way -> read returns 0x11AD33EF. A simultaneous read of the same index returns 0x11223344.
- flush_req while lines are valid, with read_req asserted during the sweep -> read outputs stay 0 and are ignored. After the sweep, all previous tags miss.
- Reset asserted at sweep cycle 100 -> flush_busy stays 1 for a further 256 cycles from the reset cycle. WAYS=1 and WAYS=8 builds pass the fill/hit scenarios.
